// File: rtl/cuckoo_lookup_engine_if.sv
// Request, hash, bucket-read and response signals of the cuckoo lookup engine.
// The engine connects through the slave modport. The environment connects
// through the master modport and owns the request source, the hash unit,
// the bucket memory and the response sink.
`timescale 1ns/1ps

interface cuckoo_lookup_engine_if #(
    parameter int IDX_BITS = 10,
    parameter int PFN_BITS = 40
);
    // Request handshake
    logic                  reqValid;
    logic                  reqReady;
    logic [44:0]           reqVPN;

    // External tabulation hash unit
    logic [44:0]           hashVPN;
    logic [1:0]            hashID;
    logic [31:0]           hashIn;

    // Bucket memory read port. Data returns one cycle after the strobe.
    logic                  memReadEn;
    logic [IDX_BITS+1:0]   memReadAddr;
    logic [45+PFN_BITS:0]  memReadData;

    // Response handshake and statistics
    logic                  respValid;
    logic                  respReady;
    logic                  respHit;
    logic [1:0]            respWay;
    logic [PFN_BITS-1:0]   respPFN;
    logic [31:0]           hitCount;
    logic [31:0]           missCount;

    modport slave (
        input  reqValid, reqVPN, hashIn, memReadData, respReady,
        output reqReady, hashVPN, hashID, memReadEn, memReadAddr,
               respValid, respHit, respWay, respPFN, hitCount, missCount
    );

    modport master (
        output reqValid, reqVPN, hashIn, memReadData, respReady,
        input  reqReady, hashVPN, hashID, memReadEn, memReadAddr,
               respValid, respHit, respWay, respPFN, hitCount, missCount
    );
endinterface

// File: rtl/cuckoo_lookup_engine.sv
// Four-way cuckoo hash table lookup engine.
// For each way 0..3 the engine presents {VPN, way} to the external hash unit.
// It reads bucket {way, hash[IDX_BITS-1:0]} and compares the stored VPN one
// cycle later. The search stops at the first valid match. A miss is reported
// after all four ways have been probed. Saturating counters track hits and
// misses at result capture time.
`timescale 1ns/1ps

module cuckoo_lookup_engine #(
    parameter int          IDX_BITS = 10,
    parameter int          PFN_BITS = 40,
    // Reset value of both statistics counters. It stays zero in normal use;
    // a nonzero value lets saturation be reached without billions of lookups.
    parameter logic [31:0] CNT_INIT = 32'd0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cuckoo_lookup_engine_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        CHECK = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Layout of one bucket entry as returned by the memory
    typedef struct packed {
        logic                valid;
        logic [44:0]         vpn;
        logic [PFN_BITS-1:0] pfn;
    } entry_t;

    state_e              state_q,      state_d;
    logic [1:0]          way_q,        way_d;
    logic [44:0]         vpn_q,        vpn_d;
    logic                resp_hit_q,   resp_hit_d;
    logic [1:0]          resp_way_q,   resp_way_d;
    logic [PFN_BITS-1:0] resp_pfn_q,   resp_pfn_d;
    logic [31:0]         hit_count_q,  hit_count_d;
    logic [31:0]         miss_count_q, miss_count_d;

    entry_t              rd_entry;
    logic                hit;
    logic                unused_hash_bits;

    // Only the low IDX_BITS of the hash select a bucket
    assign unused_hash_bits = ^bus.hashIn[31:IDX_BITS];

    // Bucket read returned for the way probed in the previous cycle
    assign rd_entry = bus.memReadData;
    assign hit      = rd_entry.valid && (rd_entry.vpn == vpn_q);

    // Next-state logic: request capture, way walk, result capture, counters
    always_comb begin
        // NOTE: each *_d defaults to its register so that branches which do not
        // assign it infer no latch and keep the flop's value.
        state_d      = state_q;
        way_d        = way_q;
        vpn_d        = vpn_q;
        resp_hit_d   = resp_hit_q;
        resp_way_d   = resp_way_q;
        resp_pfn_d   = resp_pfn_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;

        case (state_q)
            IDLE: begin
                if (bus.reqValid) begin
                    vpn_d   = bus.reqVPN;
                    way_d   = 2'd0;
                    state_d = PROBE;
                end
            end

            PROBE: begin
                state_d = CHECK;
            end

            CHECK: begin
                if (hit) begin
                    resp_hit_d = 1'b1;
                    resp_way_d = way_q;
                    resp_pfn_d = rd_entry.pfn;
                    state_d    = RESP;
                    if (hit_count_q != 32'hFFFF_FFFF) begin
                        hit_count_d = hit_count_q + 32'd1;
                    end
                end else if (way_q != 2'd3) begin
                    way_d   = way_q + 2'd1;
                    state_d = PROBE;
                end else begin
                    resp_hit_d = 1'b0;
                    resp_way_d = 2'd0;
                    resp_pfn_d = '0;
                    state_d    = RESP;
                    if (miss_count_q != 32'hFFFF_FFFF) begin
                        miss_count_d = miss_count_q + 32'd1;
                    end
                end
            end

            RESP: begin
                if (bus.respReady) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, lookup context, captured result and counters
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values,
        // independent of statement order.
        if (!rst_n) begin
            state_q      <= IDLE;
            way_q        <= 2'd0;
            vpn_q        <= '0;
            resp_hit_q   <= 1'b0;
            resp_way_q   <= 2'd0;
            resp_pfn_q   <= '0;
            hit_count_q  <= CNT_INIT;
            miss_count_q <= CNT_INIT;
        end else begin
            state_q      <= state_d;
            way_q        <= way_d;
            vpn_q        <= vpn_d;
            resp_hit_q   <= resp_hit_d;
            resp_way_q   <= resp_way_d;
            resp_pfn_q   <= resp_pfn_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Outputs decoded from the registered state
    assign bus.reqReady    = (state_q == IDLE);
    assign bus.memReadEn   = (state_q == PROBE);
    assign bus.memReadAddr = {way_q, bus.hashIn[IDX_BITS-1:0]};
    assign bus.hashVPN     = vpn_q;
    assign bus.hashID      = way_q;
    assign bus.respValid   = (state_q == RESP);
    assign bus.respHit     = resp_hit_q;
    assign bus.respWay     = resp_way_q;
    assign bus.respPFN     = resp_pfn_q;
    assign bus.hitCount    = hit_count_q;
    assign bus.missCount   = miss_count_q;

endmodule

// File: doc/cuckoo_lookup_engine.md
CUCKOO_LOOKUP_ENGINE -- requirements
Module: cuckoo_lookup_engine

Interface
REQ-001 The block SHALL have parameter IDX_BITS, default 10: bucket index width per way, taken from hashIn[IDX_BITS-1:0].
REQ-002 The block SHALL have parameter PFN_BITS, default 40: physical frame number width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-004 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- reqValid  in  1  lookup request valid
- reqReady  out  1  engine can accept a request
- reqVPN  in  45  virtual page number to look up
- hashVPN  out  45  VPN presented to the external tabulation hash unit
- hashID  out  2  hash function / way select presented to the hash unit
- hashIn  in  32  combinational hash result for (hashVPN, hashID)
- memReadEn  out  1  bucket read strobe
- memReadAddr  out  IDX_BITS+2  {way[1:0], index[IDX_BITS-1:0]}
- memReadData  in  46+PFN_BITS  {valid, vpn[44:0], pfn}, returned one cycle after memReadEn
- respValid  out  1  result valid
- respReady  in  1  consumer accepts result
- respHit  out  1  1 = translation found
- respWay  out  2  way that hit (0 on miss)
- respPFN  out  PFN_BITS  frame number on hit (0 on miss)
- hitCount  out  32  saturating hit counter
- missCount  out  32  saturating miss counter

Function
REQ-005 The FSM SHALL have states IDLE, PROBE, CHECK, RESP.
REQ-006 reqReady SHALL be 1 only in IDLE; a request is accepted on a rising edge with reqValid && reqReady.
REQ-007 On acceptance, reqVPN SHALL be latched, the way counter SHALL be cleared to 0, and the FSM SHALL move to PROBE.
REQ-008 hashVPN SHALL always equal the latched VPN, and hashID SHALL always equal the way counter.
REQ-009 In PROBE, memReadEn SHALL be 1 and memReadAddr = {way, hashIn[IDX_BITS-1:0]}; the next state SHALL be CHECK.
REQ-010 memReadEn SHALL be 0 in all states other than PROBE.
REQ-011 In CHECK, hit = memReadData.valid && (memReadData.vpn == latched VPN).
REQ-012 In CHECK, on hit: capture respHit=1, respWay=way, respPFN=memReadData.pfn, then go to RESP.
REQ-013 In CHECK, on no hit with way<3: increment way and go to PROBE.
REQ-014 In CHECK, on no hit with way==3: capture respHit=0, respWay=0, respPFN=0, then go to RESP.
REQ-015 Ways SHALL be searched in order 0..3, and the search SHALL stop at the first hit; if several ways match, the lowest-numbered way is reported.
REQ-016 Latency from the acceptance edge E0 SHALL be as follows: on a hit in way k, respValid rises after edge E(2k+2); on a miss, respValid rises after edge E8.
REQ-017 respValid SHALL be 1 only in RESP, and respHit/respWay/respPFN SHALL be held stable while respValid && !respReady.
REQ-018 When respValid && respReady on an edge, the FSM SHALL return to IDLE; the next request can be accepted no earlier than the following edge.
REQ-019 reqVPN and reqValid changes outside IDLE SHALL be ignored.
REQ-020 hitCount / missCount SHALL increment by 1 on the CHECK edge that produces a hit / final miss, and SHALL saturate at 0xFFFFFFFF (no wrap).
REQ-021 Counters SHALL count at result capture, not at handshake; a stalled response is counted once.

Reset
REQ-022 While rst_n=0, asynchronously: state=IDLE, way=0, latched VPN=0, respValid=0, respHit=0, respWay=0, respPFN=0, memReadEn=0, hitCount=0, missCount=0; reqReady=1 after release.
REQ-023 Reset asserted mid-lookup or during RESP SHALL abandon the lookup with no response and no counter update.

Verification
REQ-024 Hit in way 0: memory way0 at index hash(VPN=0x1ABC,0) = {1,0x1ABC,0x55} -> respValid after E2, respHit=1, respWay=0, respPFN=0x55, hitCount=1.
REQ-025 Hit in way 2 only: ways 0/1 valid with a different VPN, way 2 matching with pfn 0x77 -> three memReadEn pulses, respValid after E6, respWay=2, respPFN=0x77.
REQ-026 Miss: all four buckets invalid -> four memReadEn pulses with addresses {0..3, idx}, respValid after E8, respHit=0, respPFN=0, missCount=1.
REQ-027 Backpressure: respReady=0 for 5 cycles after respValid -> outputs stable, reqReady=0, counter incremented once, IDLE on the edge where respReady=1.
REQ-028 Reset mid-lookup: rst_n low during the second PROBE -> respValid=0, counters unchanged at 0, the next request completes normally.
REQ-029 Saturation: preload hitCount=0xFFFFFFFE via two further hits -> counter reads 0xFFFFFFFF and stays there.
